countdown_timer: RTL and testbench

//   Loadable down-counter/timer; the count-down counterpart of the 4-bit up-counter.
//   A rising edge on ld loads a start value. The block then decrements while en is high.
//   It flags terminal count with a one-cycle tc pulse. Used as an event/delay timer

---
 rtl/countdown_pkg.sv | 16 +
 rtl/countdown_timer_rise_detect.sv | 35 +++
 rtl/countdown_timer.sv | 104 ++++++++++
 tb/tb_countdown_timer.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/countdown_pkg.sv
// ---------------------------------------------------------------------------
// countdown_pkg
//   Shared definitions for the countdown timer block.
//   - DEFAULT_WIDTH : default counter / load-value / output width in bits
//   - state_t       : timer state, IDLE (count static) or RUN (decrementing)
// ---------------------------------------------------------------------------
package countdown_pkg;

  localparam int DEFAULT_WIDTH = 4;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

endpackage

// File: rtl/countdown_timer_rise_detect.sv
// ---------------------------------------------------------------------------
// rise_detect
//   One-bit registered rising-edge detector. The previous level of d is
//   registered every cycle; rise is high for the cycle in which d is high and
//   its registered copy is still low, so a level held high yields one pulse.
//
// Ports
//   clk    in   1   clock, state updates on posedge
//   rst_n  in   1   asynchronous active-low reset (clears the history bit)
//   d      in   1   level to watch
//   rise   out  1   d & ~d_q (combinational from d and the history bit)
// ---------------------------------------------------------------------------
module rise_detect
  import countdown_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic rise
);

  logic d_q;

  // History bit: the level of d as seen at the previous clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d_q <= 1'b0;
    end else begin
      d_q <= d;
    end
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/countdown_timer.sv
// ---------------------------------------------------------------------------
// countdown_timer
//   Loadable down-counter / timer. A rising edge on ld loads a start value
//   from in; while running and enabled the count decrements, and reaching the
//   end is flagged by a registered one-cycle tc pulse.
//
//   Build option COUNTDOWN_AUTO_RELOAD_EN:
//     defined   - at the terminal decrement the count reloads the last loaded
//                 value and the timer stays in RUN (periodic tc).
//     undefined - at the terminal decrement the count goes to 0 and the timer
//                 returns to IDLE (one-shot).
//
// Parameters
//   WIDTH  counter, load-value and output width in bits (>= 2)
//
// Ports
//   clk    in   1      clock, all state updates on posedge
//   rst_n  in   1      asynchronous active-low reset
//   ld     in   1      load request, only its rising edge acts
//   in     in   WIDTH  start / reload value, sampled on the ld rising edge
//   en     in   1      count enable; when low, count and state hold
//   oe     in   1      output enable for out
//   out    out  WIDTH  oe ? count : 0
//   tc     out  1      terminal-count pulse, one cycle
//   busy   out  1      high while the timer is in RUN
// ---------------------------------------------------------------------------
module countdown_timer
  import countdown_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ld,
  input  logic [WIDTH-1:0] in,
  input  logic             en,
  input  logic             oe,
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             busy
);

  localparam logic [WIDTH-1:0] COUNT_ONE = WIDTH'(1);

  state_t           state;
  logic [WIDTH-1:0] count;
  logic [WIDTH-1:0] reload;
  logic             ld_rise;

  rise_detect u_ld_rise (
    .clk   (clk),
    .rst_n (rst_n),
    .d     (ld),
    .rise  (ld_rise)
  );

  // Timer FSM with count, reload and tc registers.
  // A load edge beats everything else, including a coincident terminal
  // decrement, so a reload in the last cycle never shows a tc pulse.
  // The terminal step is taken at count == 1 so the count never wraps; the
  // "else" branch also covers a count of 0, which RUN never holds.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      count  <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      if (ld_rise) begin
        count  <= in;
        reload <= in;
        tc     <= 1'b0;
        state  <= (in != '0) ? RUN : IDLE;
      end else if ((state == RUN) && en) begin
        if (count > COUNT_ONE) begin
          count <= count - COUNT_ONE;
          tc    <= 1'b0;
        end else begin
          tc <= 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
          count <= reload;
          state <= RUN;
`else
          count <= '0;
          state <= IDLE;
`endif
        end
      end else begin
        tc <= 1'b0;
      end
    end
  end

  assign busy = (state == RUN);
  assign out  = oe ? count : '0;

  // While running, the count can only have moved down from the value it was
  // loaded with, so it can never exceed the remembered load value.
  count_within_reload : assert property (
    @(posedge clk) disable iff (!rst_n)
    (state == RUN) |-> (count <= reload)
  );

endmodule

// File: tb/tb_countdown_timer.sv
// ---------------------------------------------------------------------------
// tb_countdown_timer
//   Self-checking bench for countdown_timer. A behavioural reference model
//   tracks remaining count, load value and running flag as plain integers;
//   directed scenarios also compare against literal expected sequences.
// ---------------------------------------------------------------------------
module tb_countdown_timer;

  localparam int WIDTH = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             ld;
  logic [WIDTH-1:0] in;
  logic             en;
  logic             oe;
  logic [WIDTH-1:0] out;
  logic             tc;
  logic             busy;

  int total  = 0;
  int passed = 0;

  // Reference model state
  int  m_count;
  int  m_reload;
  bit  m_run;
  bit  m_tc;
  bit  m_ld_prev;

  logic [WIDTH-1:0] exp_out;
  logic             exp_tc;
  logic             exp_busy;

  countdown_timer #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .ld    (ld),
    .in    (in),
    .en    (en),
    .oe    (oe),
    .out   (out),
    .tc    (tc),
    .busy  (busy)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_count   = 0;
    m_reload  = 0;
    m_run     = 1'b0;
    m_tc      = 1'b0;
    m_ld_prev = 1'b0;
  endtask

  // Drive one cycle of inputs, advance the model by the rules, then sample
  // the DUT 1 time unit after the clock edge.
  task automatic step(input bit l, input logic [WIDTH-1:0] v, input bit e, input bit o);
    bit rise;
    ld = l;
    in = v;
    en = e;
    oe = o;
    rise = l && !m_ld_prev;
    m_ld_prev = l;
    if (rise) begin
      m_count  = int'(v);
      m_reload = int'(v);
      m_run    = (v != 0);
      m_tc     = 1'b0;
    end else if (m_run && e) begin
      if (m_count > 1) begin
        m_count = m_count - 1;
        m_tc    = 1'b0;
      end else begin
        m_tc = 1'b1;
`ifdef COUNTDOWN_AUTO_RELOAD_EN
        m_count = m_reload;
`else
        m_count = 0;
        m_run   = 1'b0;
`endif
      end
    end else begin
      m_tc = 1'b0;
    end
    exp_out  = o ? m_count[WIDTH-1:0] : '0;
    exp_tc   = m_tc;
    exp_busy = m_run;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    ld = 1'b0; in = '0; en = 1'b0; oe = 1'b1;
    model_reset();
    #12;
    total++;
    if ({out, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("[TB] FAIL reset_init: out=%0d tc=%0b busy=%0b, expected 0 0 0", out, tc, busy);
    else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 4'd5, 1'b0, 1'b1);
    step(1'b0, 4'd5, 1'b0, 1'b1);
    total++;
    if ({out, tc, busy} !== {exp_out, exp_tc, exp_busy})
      $display("[TB] FAIL reset_preload: out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
               out, tc, busy, exp_out, exp_tc, exp_busy);
    else passed++;
    // Asynchronous reset in the middle of a clock period
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if ({out, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("[TB] FAIL reset_async: out=%0d tc=%0b busy=%0b, expected 0 0 0", out, tc, busy);
    else passed++;
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 4'd9, 1'b1, 1'b1);
    total++;
    if ({out, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("[TB] FAIL reset_after: out=%0d tc=%0b busy=%0b, expected 0 0 0", out, tc, busy);
    else passed++;
  endtask

  task automatic test_one_shot();
    for (int k = 0; k <= 4; k++) begin
      step(k == 0, 4'd3, 1'b1, 1'b1);
      total++;
      if ({out, tc, busy} !== {exp_out, exp_tc, exp_busy})
        $display("[TB] FAIL one_shot_model[%0d]: out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                 k, out, tc, busy, exp_out, exp_tc, exp_busy);
      else passed++;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      total++;
      if ({out, tc, busy} !== {4'((k <= 3) ? 3 - k : 0), 1'(k == 3), 1'(k < 3)})
        $display("[TB] FAIL one_shot_seq[%0d]: out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                 k, out, tc, busy, (k <= 3) ? 3 - k : 0, k == 3, k < 3);
      else passed++;
`endif
    end
  endtask

  task automatic test_ld_held();
    for (int i = 0; i < 10; i++) begin
      step(1'b1, 4'd5, 1'b1, 1'b1);
      total++;
      if ({out, tc, busy} !== {exp_out, exp_tc, exp_busy})
        $display("[TB] FAIL ld_held_model[%0d]: out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                 i, out, tc, busy, exp_out, exp_tc, exp_busy);
      else passed++;
`ifndef COUNTDOWN_AUTO_RELOAD_EN
      total++;
      if ({out, tc, busy} !== {4'((i <= 5) ? 5 - i : 0), 1'(i == 5), 1'(i < 5)})
        $display("[TB] FAIL ld_held_seq[%0d]: out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                 i, out, tc, busy, (i <= 5) ? 5 - i : 0, i == 5, i < 5);
      else passed++;
`endif
    end
    step(1'b0, 4'd5, 1'b0, 1'b1);
  endtask

  task automatic test_en_gaps();
    step(1'b1, 4'd4, 1'b0, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1'b0, 4'd4, (i % 2) == 0, 1'b1);
      total++;
      if ({out, tc, busy} !== {exp_out, exp_tc, exp_busy})
        $display("[TB] FAIL en_gaps_model[%0d]: out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                 i, out, tc, busy, exp_out, exp_tc, exp_busy);
      else passed++;
      // Fourth enabled cycle is i == 6
      total++;
      if (tc !== 1'(i == 6))
        $display("[TB] FAIL en_gaps_tc[%0d]: tc=%0b, expected %0b", i, tc, i == 6);
      else passed++;
    end
  endtask

  task automatic test_collision();
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd3, 1'b1, 1'b1);
    step(1'b0, 4'd3, 1'b1, 1'b1);
    step(1'b0, 4'd3, 1'b1, 1'b1);
    total++;
    if (out !== 4'd1)
      $display("[TB] FAIL collision_setup: out=%0d, expected 1", out);
    else passed++;
    step(1'b1, 4'd7, 1'b1, 1'b1);
    total++;
    if ({out, tc, busy} !== {4'd7, 1'b0, 1'b1})
      $display("[TB] FAIL collision: out=%0d tc=%0b busy=%0b, expected out=7 tc=0 busy=1", out, tc, busy);
    else passed++;
    step(1'b0, 4'd7, 1'b0, 1'b1);
    total++;
    if ({out, tc, busy} !== {4'd7, 1'b0, 1'b1})
      $display("[TB] FAIL collision_hold: out=%0d tc=%0b busy=%0b, expected out=7 tc=0 busy=1", out, tc, busy);
    else passed++;
  endtask

  task automatic test_zero_load();
    step(1'b1, 4'd6, 1'b0, 1'b1);
    step(1'b0, 4'd6, 1'b1, 1'b1);
    step(1'b1, 4'd0, 1'b1, 1'b1);
    total++;
    if ({out, tc, busy} !== {4'd0, 1'b0, 1'b0})
      $display("[TB] FAIL zero_load: out=%0d tc=%0b busy=%0b, expected 0 0 0", out, tc, busy);
    else passed++;
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 4'd0, 1'b1, 1'b1);
      total++;
      if ({out, tc, busy} !== {4'd0, 1'b0, 1'b0})
        $display("[TB] FAIL zero_load_idle[%0d]: out=%0d tc=%0b busy=%0b, expected 0 0 0", i, out, tc, busy);
      else passed++;
    end
  endtask

`ifdef COUNTDOWN_AUTO_RELOAD_EN
  task automatic test_auto_reload();
    bit o;
    step(1'b0, 4'd0, 1'b0, 1'b1);
    step(1'b1, 4'd2, 1'b1, 1'b1);
    for (int i = 1; i <= 8; i++) begin
      o = (i <= 4);
      step(1'b0, 4'd2, 1'b1, o);
      total++;
      if ({out, tc, busy} !== {o ? 4'(((i % 2) == 1) ? 1 : 2) : 4'd0, 1'((i % 2) == 0), 1'b1})
        $display("[TB] FAIL auto_reload[%0d]: out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=1",
                 i, out, tc, busy, o ? (((i % 2) == 1) ? 1 : 2) : 0, (i % 2) == 0);
      else passed++;
    end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 5) == 0, 4'($urandom_range(0, 15)),
           $urandom_range(0, 3) != 0, $urandom_range(0, 4) != 0);
      total++;
      if ({out, tc, busy} !== {exp_out, exp_tc, exp_busy})
        $display("[TB] FAIL random[%0d]: out=%0d tc=%0b busy=%0b, expected out=%0d tc=%0b busy=%0b",
                 i, out, tc, busy, exp_out, exp_tc, exp_busy);
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_one_shot();
    test_ld_held();
    test_en_gaps();
    test_collision();
    test_zero_load();
`ifdef COUNTDOWN_AUTO_RELOAD_EN
    test_auto_reload();
`endif
    test_random();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
